// File: rtl/control_fsm.sv
// ----------------------------------------------------------------------------
// control_fsm
//   Multicycle RV32I control unit. Sequences fetch, decode, execute, memory
//   and writeback for one instruction at a time and drives every datapath
//   load enable, mux select, ALU/compare op and the memory handshake.
//   Outputs are combinational from the current state plus the decoded
//   instruction fields returned by the datapath.
//
// Ports
//   clk, rst           clock (rising edge) / asynchronous active-high reset
//   opcode, funct3,    instruction fields from IR (only funct7[5] is used)
//   funct7
//   br_en              comparator result from the datapath
//   mem_resp           one-cycle memory completion strobe
//   mem_addr_lo        MAR[1:0], positions the store byte enables
//   load_*             register load enables
//   *mux_sel           datapath mux selects
//   loader_mask        load width/sign (funct3 of the load)
//   aluop, cmpop       ALU operation / branch comparison
//   mem_read/write     memory strobes, held for the whole wait
//   mem_byte_enable    write byte mask
// ----------------------------------------------------------------------------
module control_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       br_en,
   input  logic       mem_resp,
   input  logic [1:0] mem_addr_lo,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_regfile,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_data_out,
   output logic       pcmux_sel,
   output logic       alumux1_sel,
   output logic       marmux_sel,
   output logic       cmpmux_sel,
   output logic [2:0] alumux2_sel,
   output logic [2:0] regfilemux_sel,
   output logic [2:0] loader_mask,
   output logic [2:0] aluop,
   output logic [2:0] cmpop,
   output logic       mem_read,
   output logic       mem_write,
   output logic [3:0] mem_byte_enable
);

   // rv32i_opcode encodings
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   // alu_ops encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SRA = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   // branch_funct3_t encodings used directly by the control
   localparam logic [2:0] CMP_BEQ  = 3'b000;
   localparam logic [2:0] CMP_BLT  = 3'b100;
   localparam logic [2:0] CMP_BLTU = 3'b110;

   // arithmetic funct3 values
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;

   // store funct3 values
   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;

   // alumux2 selects
   localparam logic [2:0] A2_I_IMM = 3'd0;
   localparam logic [2:0] A2_U_IMM = 3'd1;
   localparam logic [2:0] A2_B_IMM = 3'd2;
   localparam logic [2:0] A2_S_IMM = 3'd3;
   localparam logic [2:0] A2_RS2   = 3'd4;
   localparam logic [2:0] A2_J_IMM = 3'd5;
   localparam logic [2:0] A2_NOT1  = 3'd6;

   // regfilemux selects
   localparam logic [2:0] RF_ALU   = 3'd0;
   localparam logic [2:0] RF_BR_EN = 3'd1;
   localparam logic [2:0] RF_U_IMM = 3'd2;
   localparam logic [2:0] RF_LOAD  = 3'd3;
   localparam logic [2:0] RF_PC4   = 3'd4;

   typedef enum logic [4:0] {
      FETCH1, FETCH2, FETCH3, DECODE,
      S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR1, S_JALR2,
      CALC_ADDR, LD1, LD2, ST1, ST2
   } state_t;

   state_t state, next_state;

   // ALU op for register/immediate arithmetic. Only the register form uses
   // funct7[5] to pick sub; both forms use it to pick sra over srl.
   // slt/sltu results come from the comparator, so the ALU op is left at add.
   function automatic logic [2:0] arith_aluop(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       is_reg);
      logic [2:0] op;
      op = ALU_ADD;
      case (f3)
         F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Store byte mask aligned to the MAR low bits.
   function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                             input logic [1:0] lo);
      logic [3:0] m;
      case (f3)
         F3_SB:   m = 4'b0001 << lo;
         F3_SH:   m = 4'b0011 << {lo[1], 1'b0};
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH1;
      else     state <= next_state;
   end

   always_comb begin
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_data_out   = 1'b0;
      pcmux_sel       = 1'b0;
      alumux1_sel     = 1'b0;
      marmux_sel      = 1'b0;
      cmpmux_sel      = 1'b0;
      alumux2_sel     = A2_I_IMM;
      regfilemux_sel  = RF_ALU;
      loader_mask     = 3'b000;
      aluop           = ALU_ADD;
      cmpop           = CMP_BEQ;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 4'b1111;
      next_state      = state;

      // While reset is held the state register already sits in FETCH1, but
      // its load_mar must not reach the datapath, so decoding is gated off.
      if (!rst) begin
         case (state)
            FETCH1: begin
               load_mar   = 1'b1;
               next_state = FETCH2;
            end
            FETCH2: begin
               mem_read = 1'b1;
               load_mdr = 1'b1;
               if (mem_resp) next_state = FETCH3;
            end
            FETCH3: begin
               load_ir    = 1'b1;
               next_state = DECODE;
            end
            DECODE: begin
               case (opcode)
                  OP_IMM:   next_state = S_IMM;
                  OP_REG:   next_state = S_REG;
                  OP_LUI:   next_state = S_LUI;
                  OP_AUIPC: next_state = S_AUIPC;
                  OP_BR:    next_state = S_BR;
                  OP_JAL:   next_state = S_JAL;
                  OP_JALR:  next_state = S_JALR1;
                  OP_LOAD,
                  OP_STORE: next_state = CALC_ADDR;
                  default: begin
                     // Unsupported opcode: skip it.
                     load_pc    = 1'b1;
                     next_state = FETCH1;
                  end
               endcase
            end
            S_IMM, S_REG: begin
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               next_state   = FETCH1;
               if (state == S_REG) alumux2_sel = A2_RS2;
               if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                  // Compare rs1 against the immediate (IMM) or rs2 (REG).
                  cmpmux_sel     = (state == S_IMM);
                  cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                  regfilemux_sel = RF_BR_EN;
               end else begin
                  aluop = arith_aluop(funct3, funct7[5], state == S_REG);
               end
            end
            S_LUI: begin
               regfilemux_sel = RF_U_IMM;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               next_state     = FETCH1;
            end
            S_AUIPC: begin
               alumux1_sel  = 1'b1;
               alumux2_sel  = A2_U_IMM;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               next_state   = FETCH1;
            end
            S_BR: begin
               alumux1_sel = 1'b1;
               alumux2_sel = A2_B_IMM;
               cmpop       = funct3;
               pcmux_sel   = br_en;
               load_pc     = 1'b1;
               next_state  = FETCH1;
            end
            S_JAL: begin
               regfilemux_sel = RF_PC4;
               load_regfile   = 1'b1;
               alumux1_sel    = 1'b1;
               alumux2_sel    = A2_J_IMM;
               pcmux_sel      = 1'b1;
               load_pc        = 1'b1;
               next_state     = FETCH1;
            end
            S_JALR1: begin
               // rd and PC update on the same edge, so the target uses the
               // pre-edge rs1 even when rd == rs1.
               regfilemux_sel = RF_PC4;
               load_regfile   = 1'b1;
               pcmux_sel      = 1'b1;
               load_pc        = 1'b1;
               next_state     = S_JALR2;
            end
            S_JALR2: begin
               // PC &= ~1 to clear the target's low bit.
               alumux1_sel = 1'b1;
               alumux2_sel = A2_NOT1;
               aluop       = ALU_AND;
               pcmux_sel   = 1'b1;
               load_pc     = 1'b1;
               next_state  = FETCH1;
            end
            CALC_ADDR: begin
               marmux_sel = 1'b1;
               load_mar   = 1'b1;
               if (opcode == OP_STORE) begin
                  alumux2_sel   = A2_S_IMM;
                  load_data_out = 1'b1;
                  next_state    = ST1;
               end else begin
                  next_state    = LD1;
               end
            end
            LD1: begin
               mem_read = 1'b1;
               load_mdr = 1'b1;
               if (mem_resp) next_state = LD2;
            end
            LD2: begin
               loader_mask    = funct3;
               regfilemux_sel = RF_LOAD;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               next_state     = FETCH1;
            end
            ST1: begin
               mem_write       = 1'b1;
               mem_byte_enable = store_mask(funct3, mem_addr_lo);
               if (mem_resp) next_state = ST2;
            end
            ST2: begin
               load_pc    = 1'b1;
               next_state = FETCH1;
            end
            default: next_state = FETCH1;
         endcase
      end
   end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       br_en;
   logic       mem_resp;
   logic [1:0] mem_addr_lo;
   logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
   logic       pcmux_sel, alumux1_sel, marmux_sel, cmpmux_sel;
   logic [2:0] alumux2_sel, regfilemux_sel, loader_mask, aluop, cmpop;
   logic       mem_read, mem_write;
   logic [3:0] mem_byte_enable;

   typedef struct packed {
      logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_dout;
      logic       pcmux, a1, marmux, cmpmux;
      logic [2:0] a2, rfmux, lmask, aluop, cmpop;
      logic       rd, wr;
      logic [3:0] mbe;
   } outs_t;

   typedef struct {
      string nm;
      outs_t v;
   } exp_t;

   outs_t got;
   exp_t  sb_q[$];
   int    checks = 0;
   int    passed = 0;

   assign got = '{load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                  pcmux_sel, alumux1_sel, marmux_sel, cmpmux_sel,
                  alumux2_sel, regfilemux_sel, loader_mask, aluop, cmpop,
                  mem_read, mem_write, mem_byte_enable};

   control_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .br_en(br_en), .mem_resp(mem_resp), .mem_addr_lo(mem_addr_lo),
      .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
      .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
      .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .marmux_sel(marmux_sel),
      .cmpmux_sel(cmpmux_sel), .alumux2_sel(alumux2_sel),
      .regfilemux_sel(regfilemux_sel), .loader_mask(loader_mask), .aluop(aluop),
      .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable)
   );

   always #5 clk = ~clk;

   // Monitor: the DUT presents a control word every cycle; compare it mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (got === e.v) passed++;
         else $display("FAIL %s: got %h expected %h", e.nm, got, e.v);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic outs_t dflt();
      outs_t o;
      o = '0;
      o.mbe = 4'b1111;
      return o;
   endfunction

   function automatic outs_t f1();
      outs_t o = dflt();
      o.ld_mar = 1'b1;
      return o;
   endfunction

   function automatic outs_t f2();
      outs_t o = dflt();
      o.rd = 1'b1; o.ld_mdr = 1'b1;
      return o;
   endfunction

   function automatic outs_t f3();
      outs_t o = dflt();
      o.ld_ir = 1'b1;
      return o;
   endfunction

   // pc+4 writeback of some mux source
   function automatic outs_t wb(input logic [2:0] rfmux, input logic [2:0] a2,
                                input logic [2:0] op);
      outs_t o = dflt();
      o.ld_rf = 1'b1; o.ld_pc = 1'b1; o.rfmux = rfmux; o.a2 = a2; o.aluop = op;
      return o;
   endfunction

   task automatic step(input string nm, input outs_t v);
      exp_t e;
      e.nm = nm;
      e.v  = v;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3v,
                         input logic [6:0] f7v);
      opcode = op; funct3 = f3v; funct7 = f7v;
   endtask

   // FETCH1, FETCH2 (with stalls), FETCH3, then DECODE with the given outputs.
   task automatic fetch(input int stalls, input outs_t dec);
      step("fetch1", f1());
      mem_resp = 1'b0;
      for (int i = 0; i < stalls; i++) step("fetch2_wait", f2());
      mem_resp = 1'b1;
      step("fetch2_resp", f2());
      mem_resp = 1'b0;
      step("fetch3", f3());
      step("decode", dec);
   endtask

   initial begin
      outs_t e;
      rst = 1'b1; br_en = 1'b0; mem_resp = 1'b0; mem_addr_lo = 2'b00;
      set_ir(7'h00, 3'b000, 7'h00);
      repeat (2) @(posedge clk);
      #1;
      step("reset_hold", dflt());
      rst = 1'b0;
      step("fetch1_after_rst", f1());
      step("fetch2_pre_rst", f2());
      // Asynchronous reset while waiting on memory.
      #2;
      rst = 1'b1;
      begin
         exp_t r;
         r.nm = "rst_async_fetch2";
         r.v  = dflt();
         sb_q.push_back(r);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // addi x1,x0,5 with 3 stall cycles
      set_ir(7'b0010011, 3'b000, 7'h00);
      fetch(3, dflt());
      step("addi_imm", wb(3'd0, 3'd0, 3'b000));

      // srai: sra selected by funct7[5]
      set_ir(7'b0010011, 3'b101, 7'b0100000);
      fetch(0, dflt());
      step("srai_imm", wb(3'd0, 3'd0, 3'b010));

      // sltiu: comparator path with immediate
      set_ir(7'b0010011, 3'b011, 7'h00);
      fetch(0, dflt());
      e = wb(3'd1, 3'd0, 3'b000); e.cmpmux = 1'b1; e.cmpop = 3'b110;
      step("sltiu_imm", e);

      // sub
      set_ir(7'b0110011, 3'b000, 7'b0100000);
      fetch(0, dflt());
      step("sub_reg", wb(3'd0, 3'd4, 3'b011));

      // slt (register form, cmpmux 0)
      set_ir(7'b0110011, 3'b010, 7'h00);
      fetch(0, dflt());
      e = wb(3'd1, 3'd4, 3'b000); e.cmpop = 3'b100;
      step("slt_reg", e);

      // lui / auipc
      set_ir(7'b0110111, 3'b000, 7'h00);
      fetch(0, dflt());
      step("lui", wb(3'd2, 3'd0, 3'b000));
      set_ir(7'b0010111, 3'b000, 7'h00);
      fetch(0, dflt());
      e = wb(3'd0, 3'd1, 3'b000); e.a1 = 1'b1;
      step("auipc", e);

      // beq taken, then not taken
      for (int t = 1; t >= 0; t--) begin
         set_ir(7'b1100011, 3'b000, 7'h00);
         br_en = t[0];
         fetch(0, dflt());
         e = dflt(); e.a1 = 1'b1; e.a2 = 3'd2; e.ld_pc = 1'b1; e.pcmux = t[0];
         step(t ? "beq_taken" : "beq_not_taken", e);
      end
      br_en = 1'b0;

      // jal
      set_ir(7'b1101111, 3'b000, 7'h00);
      fetch(0, dflt());
      e = wb(3'd4, 3'd5, 3'b000); e.a1 = 1'b1; e.pcmux = 1'b1;
      step("jal", e);

      // jalr x1,0(x1)
      set_ir(7'b1100111, 3'b000, 7'h00);
      fetch(0, dflt());
      e = wb(3'd4, 3'd0, 3'b000); e.pcmux = 1'b1;
      step("jalr1", e);
      e = dflt(); e.a1 = 1'b1; e.a2 = 3'd6; e.aluop = 3'b111; e.pcmux = 1'b1; e.ld_pc = 1'b1;
      step("jalr2", e);

      // sb @ lo=11 (2 stalls), sh @ lo=10, sw
      for (int s = 0; s < 3; s++) begin
         logic [3:0] m;
         int         st;
         set_ir(7'b0100011, 3'(s), 7'h00);
         mem_addr_lo = (s == 0) ? 2'b11 : (s == 1) ? 2'b10 : 2'b01;
         m  = (s == 0) ? 4'b1000 : (s == 1) ? 4'b1100 : 4'b1111;
         st = (s == 0) ? 2 : 0;
         fetch(0, dflt());
         e = dflt(); e.a2 = 3'd3; e.marmux = 1'b1; e.ld_mar = 1'b1; e.ld_dout = 1'b1;
         step("store_calc", e);
         e = dflt(); e.wr = 1'b1; e.mbe = m;
         for (int i = 0; i < st; i++) step("store_wait", e);
         mem_resp = 1'b1;
         step("store_resp", e);
         mem_resp = 1'b0;
         e = dflt(); e.ld_pc = 1'b1;
         step("store_st2", e);
      end
      mem_addr_lo = 2'b00;

      // lhu with one stall
      set_ir(7'b0000011, 3'b101, 7'h00);
      fetch(0, dflt());
      e = dflt(); e.marmux = 1'b1; e.ld_mar = 1'b1;
      step("load_calc", e);
      step("load_wait", f2());
      mem_resp = 1'b1;
      step("load_resp", f2());
      mem_resp = 1'b0;
      e = wb(3'd3, 3'd0, 3'b000); e.lmask = 3'b101;
      step("lhu_ld2", e);

      // illegal opcode 0x7F skips straight back to FETCH1
      set_ir(7'h7F, 3'b000, 7'h00);
      e = dflt(); e.ld_pc = 1'b1;
      fetch(0, e);
      step("fetch1_after_illegal", f1());

      @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
